// File: rtl/serial_compare_pkg.sv
// Shared result encodings, FSM state type and sizing helper for serial_compare.
package serial_compare_pkg;

    localparam logic [2:0] CMP_GT   = 3'b100;
    localparam logic [2:0] CMP_LT   = 3'b010;
    localparam logic [2:0] CMP_EQ   = 3'b001;
    localparam logic [2:0] CMP_NONE = 3'b000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int idx_width(input int nibbles);
        return (nibbles <= 1) ? 1 : $clog2(nibbles);
    endfunction

endpackage

// File: rtl/nibble_cascade_cmp.sv
// One nibble stage of the magnitude compare: a differing nibble overrides the
// cascade from lower nibbles, an equal nibble passes it through.
module nibble_cascade_cmp
    import serial_compare_pkg::*;
(
    input  logic [3:0] i_nib_a,
    input  logic [3:0] i_nib_b,
    input  logic [2:0] i_casc,
    output logic [2:0] o_casc
);

    always_comb begin
        if (i_nib_a > i_nib_b) begin
            o_casc = CMP_GT;
        end else if (i_nib_a < i_nib_b) begin
            o_casc = CMP_LT;
        end else begin
            o_casc = i_casc;
        end
    end

endmodule

// File: rtl/serial_compare.sv
// Nibble-serial magnitude comparator, LSB nibble first, one nibble per clock.
// Define SERIAL_COMPARE_SIGNED_EN for two's-complement operands (default: unsigned).
module serial_compare
    import serial_compare_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             iClk,
    input  logic             iRst_n,
    input  logic             iStart,
    input  logic [WIDTH-1:0] iData_a,
    input  logic [WIDTH-1:0] iData_b,
    output logic             oBusy,
    output logic             oDone,
    output logic [2:0]       oData
);

    localparam int                NIBBLES  = WIDTH / 4;
    localparam int                IDX_W    = idx_width(NIBBLES);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NIBBLES - 1);

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] w_a_in;
    logic [WIDTH-1:0] w_b_in;
    logic [IDX_W-1:0] r_idx;
    logic [2:0]       r_casc;
    logic [2:0]       r_data;
    logic [2:0]       w_casc_next;
    logic             w_accept;
    logic             w_last;

`ifdef SERIAL_COMPARE_SIGNED_EN
    // Flipping the sign bit maps two's-complement order onto unsigned order.
    assign w_a_in = iData_a ^ {1'b1, {(WIDTH-1){1'b0}}};
    assign w_b_in = iData_b ^ {1'b1, {(WIDTH-1){1'b0}}};
`else
    assign w_a_in = iData_a;
    assign w_b_in = iData_b;
`endif

    assign w_accept = iStart && !oBusy;
    assign w_last   = (r_idx == LAST_IDX);
    assign oData    = r_data;

    nibble_cascade_cmp u_cmp (
        .i_nib_a (r_a[3:0]),
        .i_nib_b (r_b[3:0]),
        .i_casc  (r_casc),
        .o_casc  (w_casc_next)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        w_state_next = r_state;
        oBusy        = 1'b0;
        oDone        = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (iStart) w_state_next = RUN;
            end
            RUN: begin
                oBusy = 1'b1;
                if (w_last) w_state_next = DONE;
            end
            DONE: begin
                oDone        = 1'b1;
                w_state_next = iStart ? RUN : IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Operands shift right so the nibble under test is always bits [3:0].
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            r_a    <= '0;
            r_b    <= '0;
            r_idx  <= '0;
            r_casc <= CMP_EQ;
            r_data <= CMP_NONE;
        end else if (w_accept) begin
            r_a    <= w_a_in;
            r_b    <= w_b_in;
            r_idx  <= '0;
            r_casc <= CMP_EQ;
        end else if (oBusy) begin
            r_a    <= r_a >> 4;
            r_b    <= r_b >> 4;
            r_casc <= w_casc_next;
            if (w_last) begin
                r_data <= w_casc_next;
            end else begin
                r_idx <= r_idx + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_serial_compare.sv
// Directed bench for serial_compare (WIDTH=16): vector table plus hand-written
// sequences for start-while-busy, back-to-back starts and mid-run reset.
module tb_serial_compare;

    localparam int WIDTH = 16;

    logic             iClk;
    logic             iRst_n;
    logic             iStart;
    logic [WIDTH-1:0] iData_a;
    logic [WIDTH-1:0] iData_b;
    logic             oBusy;
    logic             oDone;
    logic [2:0]       oData;

    int total = 0;
    int bad   = 0;

    serial_compare #(.WIDTH(WIDTH)) dut (
        .iClk    (iClk),
        .iRst_n  (iRst_n),
        .iStart  (iStart),
        .iData_a (iData_a),
        .iData_b (iData_b),
        .oBusy   (oBusy),
        .oDone   (oDone),
        .oData   (oData)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    typedef struct {
        string       name;
        logic [15:0] a;
        logic [15:0] b;
        logic [2:0]  exp_u;
        logic [2:0]  exp_s;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [2:0] pick(input vec_t v);
`ifdef SERIAL_COMPARE_SIGNED_EN
        return v.exp_s;
`else
        return v.exp_u;
`endif
    endfunction

    // Starts one compare, scrambles inputs after acceptance, and checks timing and result.
    task automatic run_op(input string name, input logic [15:0] a, input logic [15:0] b,
                          input logic [2:0] exp);
        int busy_cnt;
        bit done_seen;
        busy_cnt  = 0;
        done_seen = 0;
        @(negedge iClk);
        iStart  = 1'b1;
        iData_a = a;
        iData_b = b;
        @(negedge iClk);
        iStart  = 1'b0;
        iData_a = ~a;
        iData_b = a;
        for (int c = 0; c < 20 && !done_seen; c++) begin
            if (oDone) begin
                done_seen = 1;
            end else begin
                if (oBusy) busy_cnt++;
                @(negedge iClk);
            end
        end
        check({name, " done_seen"}, 32'(done_seen), 32'd1);
        check({name, " busy_cycles"}, 32'(busy_cnt), 32'd4);
        check({name, " busy_in_done"}, 32'(oBusy), 32'd0);
        check({name, " result"}, 32'(oData), 32'(exp));
        @(negedge iClk);
        check({name, " done_one_cycle"}, 32'(oDone), 32'd0);
    endtask

    initial begin
        int done_cnt;
        int idle_cnt;
        int prev_k;
        logic [2:0] got;

        vecs[0] = '{"eq_1234",    16'h1234, 16'h1234, 3'b001, 3'b001};
        vecs[1] = '{"top_dom",    16'h1235, 16'h2234, 3'b010, 3'b010};
        vecs[2] = '{"sign_8000",  16'h8000, 16'h7FFF, 3'b100, 3'b010};
        vecs[3] = '{"ffff_0",     16'hFFFF, 16'h0000, 3'b100, 3'b010};
        vecs[4] = '{"zero_zero",  16'h0000, 16'h0000, 3'b001, 3'b001};
        vecs[5] = '{"low_nib_gt", 16'h0001, 16'h0000, 3'b100, 3'b100};
        vecs[6] = '{"1000_0fff",  16'h1000, 16'h0FFF, 3'b100, 3'b100};
        vecs[7] = '{"low_nib_lt", 16'h4321, 16'h4322, 3'b010, 3'b010};

        iRst_n  = 1'b0;
        iStart  = 1'b0;
        iData_a = '0;
        iData_b = '0;
        repeat (2) @(negedge iClk);
        check("reset busy", 32'(oBusy), 32'd0);
        check("reset done", 32'(oDone), 32'd0);
        check("reset data", 32'(oData), 32'd0);
        iRst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].name, vecs[i].a, vecs[i].b, pick(vecs[i]));
        end

        // Start pulse on edge 2 of a run with other operands must be ignored.
        @(negedge iClk);
        iStart = 1'b1; iData_a = 16'h0003; iData_b = 16'h0005;
        @(negedge iClk);
        iStart = 1'b0;
        @(negedge iClk);
        iStart = 1'b1; iData_a = 16'h0009; iData_b = 16'h0001;
        @(negedge iClk);
        iStart = 1'b0;
        done_cnt = 0;
        got      = 3'b000;
        for (int c = 0; c < 10; c++) begin
            if (oDone) begin
                done_cnt++;
                got = oData;
            end
            @(negedge iClk);
        end
        check("busy_start pulses", 32'(done_cnt), 32'd1);
        check("busy_start result", 32'(got), 32'(3'b010));

        // Start held high: DONE goes straight back to RUN, one result every 5 cycles.
        iStart = 1'b1; iData_a = 16'd5; iData_b = 16'd3;
        @(negedge iClk);
        done_cnt = 0;
        idle_cnt = 0;
        prev_k   = -1;
        for (int k = 0; k < 15; k++) begin
            if (!oBusy && !oDone) idle_cnt++;
            if (oDone) begin
                done_cnt++;
                check("b2b result", 32'(oData), 32'(3'b100));
                if (prev_k >= 0) check("b2b period", 32'(k - prev_k), 32'd5);
                else             check("b2b first latency", 32'(k), 32'd4);
                prev_k = k;
            end
            if (k < 14) @(negedge iClk);
        end
        iStart = 1'b0;
        check("b2b done count", 32'(done_cnt), 32'd3);
        check("b2b idle cycles", 32'(idle_cnt), 32'd0);
        repeat (2) @(negedge iClk);

        // Reset on edge 2 of a run aborts it without a done pulse.
        iStart = 1'b1; iData_a = 16'h1234; iData_b = 16'h1234;
        @(negedge iClk);
        iStart = 1'b0;
        @(posedge iClk);
        @(posedge iClk);
        #1 iRst_n = 1'b0;
        @(negedge iClk);
        check("midrst busy", 32'(oBusy), 32'd0);
        check("midrst done", 32'(oDone), 32'd0);
        check("midrst data", 32'(oData), 32'd0);
        iRst_n = 1'b1;
        done_cnt = 0;
        for (int c = 0; c < 8; c++) begin
            if (oDone || oBusy) done_cnt++;
            @(negedge iClk);
        end
        check("midrst stays idle", 32'(done_cnt), 32'd0);
        run_op("after_rst", 16'hA000, 16'h9FFF, 3'b100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
